lut_layer_sequencer: RTL and testbench

LUT_LAYER_SEQUENCER -- requirements
Module: lut_layer_sequencer

---
 rtl/lut_layer_sequencer.sv | 145 ++++++++++++++
 tb/tb_lut_layer_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexes NUM_NEURONS LUT-neurons over one shared LUT bank port.
// Gathers each neuron's fan-in from a registered input frame and collects results into an output frame.
module lut_layer_sequencer #(
  parameter int NUM_IN      = 16,
  parameter int IN_BITS     = 2,
  parameter int FAN_IN      = 4,
  parameter int NUM_NEURONS = 8,
  parameter int OUT_BITS    = 2,
  parameter int LUT_LAT     = 1,
  localparam int SEL_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int ADDR_W = FAN_IN * IN_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_IN*IN_BITS-1:0]     in_data,
  input  logic                          cfg_we,
  input  logic [SEL_W-1:0]              cfg_addr,
  input  logic [FAN_IN*IDX_W-1:0]       cfg_data,
  output logic                          cfg_err,
  output logic [SEL_W-1:0]              lut_sel,
  output logic [ADDR_W-1:0]             lut_addr,
  output logic                          lut_req,
  input  logic [OUT_BITS-1:0]           lut_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  output logic                          busy
);

  // state | meaning
  // IDLE  | waiting for a frame, connectivity writable
  // RUN   | issuing one neuron per cycle to the LUT bank
  // DRAIN | all issued, waiting for outstanding LUT results
  // DONE  | out_data valid and held until out_ready
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_NEURONS - 1);

  state_t state_q, state_d;

  logic [NUM_IN*IN_BITS-1:0]       act_q;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q;
  logic [SEL_W-1:0]                cnt_q;
  logic [IDX_W-1:0]                conn_q [NUM_NEURONS][FAN_IN];

  logic             accept;
  logic             cfg_ok;
  logic             em_v;
  logic [SEL_W-1:0] em_idx;

  assign accept    = (state_q == IDLE) && in_valid;
  assign cfg_ok    = (state_q == IDLE) && ({1'b0, cfg_addr} < (SEL_W + 1)'(NUM_NEURONS));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign lut_req   = (state_q == RUN);
  assign lut_sel   = (state_q == RUN) ? cnt_q : '0;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = RUN;
      RUN:   if (cnt_q == LAST) state_d = (LUT_LAT == 0) ? DONE : DRAIN;
      DRAIN: if (em_v && (em_idx == LAST)) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range connectivity indices fall back to activation 0.
  always_comb begin
    logic [IDX_W-1:0] ci;
    ci       = '0;
    lut_addr = '0;
    if (state_q == RUN) begin
      for (int k = 0; k < FAN_IN; k++) begin
        ci = conn_q[cnt_q][k];
        if (int'(ci) < NUM_IN) lut_addr[k*IN_BITS +: IN_BITS] = act_q[ci*IN_BITS +: IN_BITS];
        else                   lut_addr[k*IN_BITS +: IN_BITS] = act_q[IN_BITS-1:0];
      end
    end
  end

  generate
    if (LUT_LAT == 0) begin : g_comb
      assign em_v   = lut_req;
      assign em_idx = lut_sel;
    end else begin : g_pipe
      logic [LUT_LAT-1:0] pv_q;
      logic [SEL_W-1:0]   pi_q [LUT_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv_q <= '0;
          for (int i = 0; i < LUT_LAT; i++) pi_q[i] <= '0;
        end else begin
          pv_q[0] <= lut_req;
          pi_q[0] <= lut_sel;
          for (int i = 1; i < LUT_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pi_q[i] <= pi_q[i-1];
          end
        end
      end

      assign em_v   = pv_q[LUT_LAT-1];
      assign em_idx = pi_q[LUT_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q      <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
      cfg_err    <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++)
        for (int k = 0; k < FAN_IN; k++)
          conn_q[n][k] <= '0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok)
        for (int k = 0; k < FAN_IN; k++)
          conn_q[cfg_addr][k] <= cfg_data[k*IDX_W +: IDX_W];
      if (accept) begin
        act_q      <= in_data;
        out_data_q <= '0;
        cnt_q      <= '0;
      end else begin
        if (state_q == RUN) cnt_q <= cnt_q + 1'b1;
        if (em_v) out_data_q[em_idx*OUT_BITS +: OUT_BITS] <= lut_data;
      end
    end
  end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer: default latency instance plus LUT_LAT=0 and LUT_LAT=3 instances.
// Ideal LUT banks with the matching latency sit on each instance's LUT port.
module tb_lut_layer_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;

  logic        in_ready, cfg_err, lut_req, out_valid, busy;
  logic [2:0]  lut_sel;
  logic [7:0]  lut_addr;
  logic [1:0]  ld1;
  logic [15:0] out_data;

  logic        iv0 = 1'b0, iv3 = 1'b0, or0 = 1'b1, or3 = 1'b1;
  logic        ir0, ce0, lr0, ov0, b0, ir3, ce3, lr3, ov3, b3;
  logic [2:0]  sel0, sel3;
  logic [7:0]  addr0, addr3;
  logic [1:0]  ld0, ld3, l3a, l3b;
  logic [15:0] od0, od3;

  logic [3:0] conn_m [8][4];

  function automatic logic [1:0] lutf(input logic [2:0] s, input logic [7:0] a);
    logic [3:0] t;
    t = {2'b0, a[1:0]} + {2'b0, a[3:2]} + {2'b0, (a[5:4] ^ a[7:6])} + {1'b0, s};
    return t[1:0] ^ {a[7], a[0] & a[2]};
  endfunction

  function automatic logic [15:0] model_out(input logic [31:0] act, input bit use_zero);
    logic [15:0] r;
    logic [7:0]  a;
    logic [3:0]  ix;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      a = '0;
      for (int k = 0; k < 4; k++) begin
        ix = use_zero ? 4'd0 : conn_m[n][k];
        a[k*2 +: 2] = act[ix*2 +: 2];
      end
      r[n*2 +: 2] = lutf(3'(n), a);
    end
    return r;
  endfunction

  always @(posedge clk) ld1 <= lutf(lut_sel, lut_addr);
  assign ld0 = lutf(sel0, addr0);
  always @(posedge clk) begin
    l3a <= lutf(sel3, addr3);
    l3b <= l3a;
    ld3 <= l3b;
  end

  lut_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .lut_sel(lut_sel), .lut_addr(lut_addr), .lut_req(lut_req), .lut_data(ld1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  lut_layer_sequencer #(.LUT_LAT(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
    .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_data(16'd0), .cfg_err(ce0),
    .lut_sel(sel0), .lut_addr(addr0), .lut_req(lr0), .lut_data(ld0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .busy(b0)
  );

  lut_layer_sequencer #(.LUT_LAT(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_data(in_data),
    .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_data(16'd0), .cfg_err(ce3),
    .lut_sel(sel3), .lut_addr(addr3), .lut_req(lr3), .lut_data(ld3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .busy(b3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] act, input logic [15:0] want, input bit chk_issue,
                           input bit inject_run, input bit cfg_same);
    int t0, lat;
    t0 = cyc; lat = -1;
    in_data = act; in_valid = 1'b1;
    if (cfg_same) begin cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 16'hFFFF; end
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    for (int i = 1; i < 40; i++) begin
      if (chk_issue && i <= 8) begin
        chk("lut_req_run", {31'b0, lut_req}, 1);
        chk("lut_sel_run", {29'b0, lut_sel}, i - 1);
      end
      if (inject_run && i == 4) chk("cfg_err_pulse", {31'b0, cfg_err}, 1);
      if (inject_run && i == 5) chk("cfg_err_clear", {31'b0, cfg_err}, 0);
      if (out_valid) begin lat = cyc - t0; break; end
      if (inject_run && i == 3) begin cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'h5555; end
      else cfg_we = 1'b0;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    chk("out_valid", {31'b0, out_valid}, 1);
    chk("latency", lat, 10);
    chk("out_data", {16'b0, out_data}, {16'b0, want});
    chk("lut_req_done", {31'b0, lut_req}, 0);
  endtask

  logic [31:0] act_a = 32'hE4B1_27D8;
  logic [31:0] act_b = 32'h1F3C_9A65;
  logic [31:0] act_c = 32'h5A5A_A5A6;
  logic [15:0] exp_a, exp_b;

  initial begin
    int t0, f0, s0, f3, s3;
    logic [15:0] c0, c3;
    for (int n = 0; n < 8; n++) for (int k = 0; k < 4; k++) conn_m[n][k] = '0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_lut_req", {31'b0, lut_req}, 0);
    chk("rst_cfg_err", {31'b0, cfg_err}, 0);
    chk("rst_out_data", {16'b0, out_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 1);

    // Latency and back-to-back interval for LUT_LAT = 0 and 3, connectivity all zero
    in_data = act_c; iv0 = 1'b1; iv3 = 1'b1;
    t0 = cyc; f0 = -1; s0 = -1; f3 = -1; s3 = -1; c0 = '0; c3 = '0;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (ov0) begin
        if (f0 < 0) begin f0 = cyc - t0; c0 = od0; end
        else if (s0 < 0) s0 = cyc - t0;
      end
      if (ov3) begin
        if (f3 < 0) begin f3 = cyc - t0; c3 = od3; end
        else if (s3 < 0) s3 = cyc - t0;
      end
    end
    iv0 = 1'b0; iv3 = 1'b0;
    chk("lat0_first", f0, 9);
    chk("lat0_interval", s0 - f0, 10);
    chk("lat3_first", f3, 12);
    chk("lat3_interval", s3 - f3, 13);
    chk("lat0_data", {16'b0, c0}, {16'b0, model_out(act_c, 1'b1)});
    chk("lat3_data", {16'b0, c3}, {16'b0, model_out(act_c, 1'b1)});
    repeat (20) @(negedge clk);

    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 4; k++) conn_m[n][k] = 4'(4 * n + k);
      cfg_write(3'(n), {conn_m[n][3], conn_m[n][2], conn_m[n][1], conn_m[n][0]});
      chk("cfg_err_idle", {31'b0, cfg_err}, 0);
    end

    exp_a = model_out(act_a, 1'b0);
    exp_b = model_out(act_b, 1'b0);

    out_ready = 1'b1;
    run_frame(act_a, exp_a, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_after_done", {31'b0, in_ready}, 1);

    out_ready = 1'b0;
    run_frame(act_b, exp_b, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_data", {16'b0, out_data}, {16'b0, exp_b});
      chk("hold_in_ready", {31'b0, in_ready}, 0);
      chk("hold_out_valid", {31'b0, out_valid}, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'b0, in_ready}, 1);
    chk("release_out_valid", {31'b0, out_valid}, 0);

    run_frame(act_a, exp_a, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    for (int k = 0; k < 4; k++) conn_m[2][k] = 4'hF;
    run_frame(act_a, model_out(act_a, 1'b0), 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    in_data = act_b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("drain_busy", {31'b0, busy}, 1);
    chk("drain_out_valid", {31'b0, out_valid}, 0);
    chk("drain_lut_req", {31'b0, lut_req}, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_out_data", {16'b0, out_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) for (int k = 0; k < 4; k++) conn_m[n][k] = '0;
    @(negedge clk);
    run_frame(act_c, model_out(act_c, 1'b0), 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
